dual_rail_rx: RTL and testbench

- Receiving end of a complementary (dual-rail) bit link, where each bit is carried as a true/complement pair like our y/ybar flop outputs.
- Classifies each sampled pair, deserializes legal bits into WIDTH-bit words and presents them on a valid/ready output with a one-word holding register.
- Flags illegal pairs and output overruns.
- Sits downstream of any dual-rail transmitter or flop stage in the assertion test designs.

---
 rtl/dual_rail_pkg.sv | 24 ++
 rtl/dual_rail_rx_if.sv | 23 ++
 rtl/dual_rail_decode.sv | 30 +++
 rtl/dual_rail_rx.sv | 126 ++++++++++++
 tb/tb_dual_rail_rx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dual_rail_pkg.sv
// Shared types for the dual-rail link: pair encoding, receiver state, pair classifier.
// The transmitter reuses the same encoding from here.
package dual_rail_pkg;

    localparam int unsigned PAIR_W = 2;

    typedef enum logic [PAIR_W-1:0] {
        PAIR_SPACER  = 2'b00,
        PAIR_ZERO    = 2'b01,
        PAIR_ONE     = 2'b10,
        PAIR_ILLEGAL = 2'b11
    } pair_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rx_state_t;

    // Pair is encoded {p, n}, so the enum value is the raw rail concatenation.
    function automatic pair_t classify(input logic p, input logic n);
        return pair_t'({p, n});
    endfunction

endpackage

// File: rtl/dual_rail_rx_if.sv
// Dual-rail input pairs plus the valid/ready word output of the receiver.
interface dual_rail_rx_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_p;
    logic             in_n;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, in_p, in_n, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_valid, in_p, in_n, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/dual_rail_decode.sv
// Combinational classifier turning a sampled true/complement pair into bit/illegal strobes.
module dual_rail_decode
    import dual_rail_pkg::*;
(
    input  logic valid_i,
    input  logic p_i,
    input  logic n_i,
    output logic is_bit_o,
    output logic bit_val_o,
    output logic is_illegal_o
);

    always_comb begin
        is_bit_o     = 1'b0;
        bit_val_o    = 1'b0;
        is_illegal_o = 1'b0;
        if (valid_i) begin
            case (classify(p_i, n_i))
                PAIR_ONE: begin
                    is_bit_o  = 1'b1;
                    bit_val_o = 1'b1;
                end
                PAIR_ZERO:    is_bit_o     = 1'b1;
                PAIR_ILLEGAL: is_illegal_o = 1'b1;
                default:      ;
            endcase
        end
    end

endmodule

// File: rtl/dual_rail_rx.sv
// Dual-rail receiver: deserializes legal bits into words held in a one-entry output
// register, flagging illegal pairs (err) and words lost to a full holding register (ovf).
module dual_rail_rx
    import dual_rail_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    dual_rail_rx_if.slave    bus,
    output logic             err,
    output logic             ovf,
    output logic [CNT_W-1:0] bit_cnt
);

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shifted;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d, ovf_q, ovf_d;
    logic             is_bit, bit_val, is_illegal;
    logic             complete, handshake, load;

    dual_rail_decode u_decode (
        .valid_i      (bus.in_valid),
        .p_i          (bus.in_p),
        .n_i          (bus.in_n),
        .is_bit_o     (is_bit),
        .bit_val_o    (bit_val),
        .is_illegal_o (is_illegal)
    );

    always_comb begin
        if (MSB_FIRST) shifted = {shift_q[WIDTH-2:0], bit_val};
        else           shifted = {bit_val, shift_q[WIDTH-1:1]};
    end

    assign complete  = is_bit && (cnt_q == CNT_W'(WIDTH - 1));
    assign handshake = (state_q == FULL) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rstn) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (complete) state_d = FULL;
            FULL:    if (handshake && !complete) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // A completed word is loaded unless the holder is full and not being drained.
    always_comb begin
        load  = 1'b0;
        ovf_d = 1'b0;
        case (state_q)
            EMPTY: load = complete;
            FULL: begin
                load  = complete && bus.out_ready;
                ovf_d = complete && !bus.out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        err_d   = is_illegal;
        if (is_illegal) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (is_bit) begin
            shift_d = shifted;
            cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
        end
        data_d = load ? shifted : data_q;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = (state_q == FULL);
    assign err           = err_q;
    assign ovf           = ovf_q;
    assign bit_cnt       = cnt_q;

    // Runtime invariants; previous-cycle stall is tracked to check data stability.
    logic             stall_prev_q;
    logic [WIDTH-1:0] data_prev_q;

    always @(posedge clk) begin
        if (!rstn) begin
            assert (cnt_q < CNT_W'(WIDTH))
                else $error("bit_cnt out of range: %0d", cnt_q);
            assert (!(err_q && ovf_q))
                else $error("err and ovf asserted together");
            if (stall_prev_q) begin
                assert (data_q == data_prev_q)
                    else $error("out_data changed while stalled");
            end
        end
        stall_prev_q <= !rstn && bus.out_valid && !bus.out_ready;
        data_prev_q  <= data_q;
    end

endmodule

// File: tb/tb_dual_rail_rx.sv
// Checks MSB-first and LSB-first receivers side by side against a word-level reference model.
module tb_dual_rail_rx;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    dual_rail_rx_if #(.WIDTH(W)) bus_m ();
    dual_rail_rx_if #(.WIDTH(W)) bus_l ();

    logic          err_m, ovf_m, err_l, ovf_l;
    logic [CW-1:0] cnt_m, cnt_l;

    dual_rail_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus_m.slave),
        .err     (err_m),
        .ovf     (ovf_m),
        .bit_cnt (cnt_m)
    );

    dual_rail_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus_l.slave),
        .err     (err_l),
        .ovf     (ovf_l),
        .bit_cnt (cnt_l)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: list of received bits of the current word plus the held word.
    bit           bits_q[$];
    bit           hv;
    logic [W-1:0] hd_m, hd_l;
    bit           err_e, ovf_e;

    task automatic model_step(input bit r, input bit v, input bit p, input bit n, input bit rdy);
        bit           hs;
        bit           done;
        logic [W-1:0] wm, wl;
        if (r) begin
            bits_q.delete();
            hv = 0; hd_m = '0; hd_l = '0; err_e = 0; ovf_e = 0;
            return;
        end
        hs    = hv && rdy;
        done  = 0;
        err_e = 0;
        ovf_e = 0;
        if (v && p && n) begin
            err_e = 1;
            bits_q.delete();
        end else if (v && (p != n)) begin
            bits_q.push_back(p);
            if (bits_q.size() == int'(W)) done = 1;
        end
        if (done) begin
            wm = '0;
            wl = '0;
            for (int i = 0; i < int'(W); i++) begin
                wm = W'(wm * 2 + W'(bits_q[i]));
                if (bits_q[i]) wl = wl + W'(1 << i);
            end
            if (!hv || hs) begin
                hv = 1; hd_m = wm; hd_l = wl;
            end else begin
                ovf_e = 1;
            end
            bits_q.delete();
        end else if (hs) begin
            hv = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit v, input bit p, input bit n, input bit rdy);
        rstn           = r;
        bus_m.in_valid = v;  bus_l.in_valid = v;
        bus_m.in_p     = p;  bus_l.in_p     = p;
        bus_m.in_n     = n;  bus_l.in_n     = n;
        bus_m.out_ready = rdy; bus_l.out_ready = rdy;
        @(posedge clk);
        model_step(r, v, p, n, rdy);
        #1;
        check("msb.valid", 32'(bus_m.out_valid), 32'(hv));
        check("msb.data",  32'(bus_m.out_data),  32'(hd_m));
        check("msb.err",   32'(err_m),           32'(err_e));
        check("msb.ovf",   32'(ovf_m),           32'(ovf_e));
        check("msb.cnt",   32'(cnt_m),           32'(bits_q.size()));
        check("lsb.valid", 32'(bus_l.out_valid), 32'(hv));
        check("lsb.data",  32'(bus_l.out_data),  32'(hd_l));
        check("lsb.err",   32'(err_l),           32'(err_e));
        check("lsb.ovf",   32'(ovf_l),           32'(ovf_e));
        check("lsb.cnt",   32'(cnt_l),           32'(bits_q.size()));
    endtask

    task automatic send_bit(input bit b, input bit rdy);
        cyc(1'b0, 1'b1, b, !b, rdy);
    endtask

    // Sends the top 'nb' bits of w, first bit on the wire is w[W-1].
    task automatic send_bits(input logic [W-1:0] w, input int nb, input bit gaps, input bit rdy);
        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0, rdy);
                cyc(1'b0, 1'b0, 1'b1, 1'b1, rdy);
            end
            send_bit(w[W-1-i], rdy);
        end
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0xA5 back to back, then with spacers and idle gaps
        send_bits(8'hA5, 8, 1'b0, 1'b1);
        idle(1'b1);
        send_bits(8'hA5, 8, 1'b1, 1'b1);
        idle(1'b1);

        // partial word aborted by an illegal pair, then 0x3C
        send_bits(8'hE0, 3, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        send_bits(8'h3C, 8, 1'b0, 1'b1);
        idle(1'b1);

        // overrun: 0x11 held, 0x22 dropped, then drained
        send_bits(8'h11, 8, 1'b0, 1'b0);
        send_bits(8'h22, 8, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // 0x66 completes in the same cycle the held 0x55 is accepted
        send_bits(8'h55, 8, 1'b0, 1'b0);
        send_bits(8'h66, 7, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // reset mid-word with 0x77 held, then 0x81
        send_bits(8'h77, 8, 1'b0, 1'b0);
        send_bits(8'hFF, 5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(8'h81, 8, 1'b0, 1'b0);
        idle(1'b1);

        // single leading one: 0x80 MSB-first, 0x01 LSB-first
        send_bits(8'h80, 8, 1'b0, 1'b0);
        check("lsb.word01", 32'(bus_l.out_data), 32'h01);
        check("msb.word80", 32'(bus_m.out_data), 32'h80);
        idle(1'b1);

        for (int c = 0; c < 3000; c++) begin
            bit r, v, p, n, rdy;
            int k;
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 7);
            rdy = 1'(($urandom_range(0, 1)));
            k   = int'($urandom_range(0, 99));
            if (k < 80) begin
                p = 1'($urandom_range(0, 1));
                n = !p;
            end else if (k < 96) begin
                p = 1'b0; n = 1'b0;
            end else begin
                p = 1'b1; n = 1'b1;
            end
            cyc(r, v, p, n, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
